sonar_echo_detector: RTL and testbench

Downstream stage of the sonar receive FIR filter. Consumes each filtered Q15 sample together with its one-cycle valid strobe and tracks a fast-attack / slow-decay amplitude envelope. After a transmit start it measures time-of-flight in sample periods: it ignores a blanking window, then requires a debounced threshold crossing, and reports the sample index of the first echo, or a timeout. The result feeds the SoC register/interrupt block.

---
 rtl/sonar_pkg.sv | 19 +
 rtl/sonar_echo_detector_envelope.sv | 64 ++++++
 rtl/sonar_echo_detector.sv | 142 ++++++++++++++
 tb/tb_sonar_echo_detector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared sonar receive-chain types and constants: FSM states, the timeout
// marker and the default datapath widths used by the FIR, echo and register blocks.
package sonar_pkg;

    localparam int DEF_N     = 16;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SHIFT = 4;

    // Reported in tof when the listen window expires without an echo.
    localparam logic [DEF_CNT_W-1:0] TOF_NONE = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        LISTEN = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sonar_echo_detector_envelope.sv
// Fast-attack / slow-decay amplitude envelope of a signed sample stream.
// env_next is exposed so the detector can compare without an extra sample of lag.
module envelope_follower
    import sonar_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic signed [N-1:0] x_in,
    input  logic                x_valid,
    output logic        [N-1:0] env,
    output logic        [N-1:0] env_next
);

    localparam logic [N-1:0] MAG_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] X_MIN   = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] x_u;
    logic [N-1:0] mag;
    logic [N-1:0] env_q;
    logic [N-1:0] env_d;

    assign x_u = x_in;

    // The most negative input has no positive twin, so it saturates.
    always_comb begin
        mag = x_u;
        if (x_u[N-1]) begin
            if (x_u == X_MIN) begin
                mag = MAG_MAX;
            end else begin
                mag = ~x_u + 1'b1;
            end
        end
    end

    always_comb begin
        env_d = env_q;
        if (clr) begin
            env_d = '0;
        end else if (x_valid) begin
            if (mag > env_q) begin
                env_d = mag;
            end else begin
                env_d = env_q - (env_q >> SHIFT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    assign env      = env_q;
    assign env_next = env_d;

endmodule

// File: rtl/sonar_echo_detector.sv
// Time-of-flight measurement after a transmit burst: blanking, debounced
// threshold detection on the envelope, and timeout handling.
module sonar_echo_detector
    import sonar_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] x_in,
    input  logic                x_valid,
    input  logic                start,
    input  logic        [N-1:0] threshold,
    input  logic    [CNT_W-1:0] blank,
    input  logic    [CNT_W-1:0] timeout,
    input  logic          [3:0] debounce,
    output logic        [N-1:0] env,
    output logic                busy,
    output logic                done,
    output logic                detected,
    output logic    [CNT_W-1:0] tof
);

    localparam logic [CNT_W-1:0] TOF_TIMEOUT = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       deb_q, deb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             detected_q, detected_d;
    logic [CNT_W-1:0] tof_q, tof_d;

    logic [N-1:0]     env_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       deb_req;
    logic [4:0]       deb_p1;
    logic             above;

    // A start discards any sample arriving with it, so it also clears the envelope.
    envelope_follower #(
        .N     (N),
        .SHIFT (SHIFT)
    ) u_env (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .x_in     (x_in),
        .x_valid  (x_valid),
        .env      (env),
        .env_next (env_next)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign deb_req = (debounce == 4'd0) ? 5'd1 : {1'b0, debounce};
    assign deb_p1  = {1'b0, deb_q} + 5'd1;
    assign above   = env_next > threshold;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        deb_d      = deb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        detected_d = detected_q;
        tof_d      = tof_q;

        if (start) begin
            state_d    = (blank != '0) ? BLANK : LISTEN;
            cnt_d      = '0;
            deb_d      = '0;
            busy_d     = 1'b1;
            detected_d = 1'b0;
            tof_d      = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (x_valid) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == blank - 1'b1) begin
                            state_d = LISTEN;
                        end
                    end
                end
                LISTEN: begin
                    if (x_valid) begin
                        cnt_d = cnt_inc;
                        deb_d = above ? deb_p1[3:0] : 4'd0;
                        // Detection takes priority over a coincident timeout.
                        if (above && (deb_p1 >= deb_req)) begin
                            state_d    = DONE;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            detected_d = 1'b1;
                            tof_d      = cnt_q;
                        end else if ((timeout != '0) && (cnt_q == timeout - 1'b1)) begin
                            state_d    = DONE;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            detected_d = 1'b0;
                            tof_d      = TOF_TIMEOUT;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            deb_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            detected_q <= 1'b0;
            tof_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            detected_q <= detected_d;
            tof_q      <= tof_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign detected = detected_q;
    assign tof      = tof_q;

endmodule

// File: tb/tb_sonar_echo_detector.sv
// Directed checks of envelope, blanking, debounce, timeout, restart and reset
// behaviour of sonar_echo_detector against hand-computed values.
module tb_sonar_echo_detector;
    import sonar_pkg::*;

    logic               clk;
    logic               rst;
    logic signed [15:0] x_in;
    logic               x_valid;
    logic               start;
    logic        [15:0] threshold;
    logic        [15:0] blank;
    logic        [15:0] timeout;
    logic         [3:0] debounce;
    logic        [15:0] env;
    logic               busy;
    logic               done;
    logic               detected;
    logic        [15:0] tof;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen;

    sonar_echo_detector dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .start     (start),
        .threshold (threshold),
        .blank     (blank),
        .timeout   (timeout),
        .debounce  (debounce),
        .env       (env),
        .busy      (busy),
        .done      (done),
        .detected  (detected),
        .tof       (tof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic sample(input logic signed [15:0] x);
        x_in    = x;
        x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        if (done) done_seen++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (done) done_seen++;
    endtask

    task automatic configure(input logic [15:0] th, input logic [15:0] bl,
                             input logic [15:0] to, input logic [3:0] db);
        threshold = th;
        blank     = bl;
        timeout   = to;
        debounce  = db;
    endtask

    initial begin
        rst = 1'b1; x_in = '0; x_valid = 1'b0; start = 1'b0;
        configure(16'd1000, 16'd0, 16'd0, 4'd1);
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_env", env, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_det", detected, 0);
        check("rst_tof", tof, 0);

        // Envelope attack/decay in IDLE
        sample(-16'sd32768);
        check("env_sat", env, 32767);
        sample(16'sd0);
        check("env_decay1", env, 30720);
        sample(16'sd0);
        check("env_decay2", env, 28800);
        check("idle_busy", busy, 0);

        // Blanking
        configure(16'd1000, 16'd3, 16'd0, 4'd1);
        pulse_start();
        check("blk_env0", env, 0);
        check("blk_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            sample(16'sd20000);
            check("blk_nodet", detected, 0);
            check("blk_nodone", done, 0);
        end
        sample(16'sd0);
        check("blk_env", env, 18750);
        check("blk_det", detected, 1);
        check("blk_tof", tof, 3);
        check("blk_done", done, 1);
        check("blk_busy_fall", busy, 0);
        @(negedge clk);
        check("blk_done_pulse", done, 0);
        check("blk_det_hold", detected, 1);

        // Debounce, detection
        configure(16'd1000, 16'd0, 16'd0, 4'd3);
        pulse_start();
        sample(16'sd0); sample(16'sd0); sample(16'sd2000); sample(16'sd0);
        check("deb_early", detected, 0);
        check("deb_env3", env, 1875);
        sample(16'sd0);
        check("deb_env4", env, 1758);
        check("deb_det", detected, 1);
        check("deb_tof", tof, 4);
        check("deb_done", done, 1);

        // Debounce reset by a sub-threshold sample
        configure(16'd1800, 16'd0, 16'd0, 4'd3);
        pulse_start();
        done_seen = 0;
        sample(16'sd0); sample(16'sd0); sample(16'sd2000); sample(16'sd0); sample(16'sd0);
        check("debr_nodet", detected, 0);
        check("debr_busy", busy, 1);
        sample(16'sd2000); sample(16'sd0); sample(16'sd0);
        check("debr_reset", detected, 0);
        check("debr_nodone", done_seen, 0);

        // Timeout
        configure(16'd32767, 16'd0, 16'd10, 4'd1);
        pulse_start();
        for (int i = 0; i < 9; i++) sample(16'sd30000);
        check("to_busy9", busy, 1);
        check("to_nodone9", done, 0);
        sample(16'sd30000);
        check("to_done", done, 1);
        check("to_det", detected, 0);
        check("to_tof", tof, TOF_NONE);
        check("to_busy", busy, 0);

        // Timeout disabled
        configure(16'd32767, 16'd0, 16'd0, 4'd1);
        pulse_start();
        done_seen = 0;
        for (int i = 0; i < 40; i++) sample(16'sd30000);
        check("to0_busy", busy, 1);
        check("to0_nodone", done_seen, 0);

        // Start with simultaneous sample: sample ignored, not counted
        configure(16'd32767, 16'd0, 16'd3, 4'd1);
        x_in = 16'sd20000; x_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        x_valid = 1'b0; start = 1'b0;
        check("sim_env0", env, 0);
        check("sim_busy", busy, 1);
        sample(16'sd100); sample(16'sd100);
        check("sim_notyet", done, 0);
        sample(16'sd100);
        check("sim_done", done, 1);
        check("sim_tof", tof, TOF_NONE);

        // Restart from LISTEN at cnt=5
        configure(16'd32767, 16'd0, 16'd8, 4'd1);
        pulse_start();
        for (int i = 0; i < 5; i++) sample(16'sd50);
        done_seen = 0;
        pulse_start();
        check("rs_busy", busy, 1);
        for (int i = 0; i < 7; i++) sample(16'sd50);
        check("rs_nodone", done_seen, 0);
        check("rs_busy7", busy, 1);
        sample(16'sd50);
        check("rs_done", done, 1);

        // Detection on index timeout-1 beats timeout
        configure(16'd1000, 16'd0, 16'd4, 4'd1);
        pulse_start();
        sample(16'sd0); sample(16'sd0); sample(16'sd0);
        sample(16'sd5000);
        check("dt_det", detected, 1);
        check("dt_tof", tof, 3);
        check("dt_done", done, 1);

        // Reset mid-LISTEN, then a fresh measurement
        configure(16'd32767, 16'd0, 16'd0, 4'd1);
        pulse_start();
        sample(16'sd5000); sample(16'sd5000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_env", env, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_tof", tof, 0);
        @(negedge clk);
        check("mrst_nodone", done, 0);
        configure(16'd1000, 16'd2, 16'd0, 4'd2);
        pulse_start();
        sample(16'sd3000); sample(16'sd3000); sample(16'sd3000);
        check("fresh_nodet", detected, 0);
        sample(16'sd3000);
        check("fresh_det", detected, 1);
        check("fresh_tof", tof, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
